// File: rtl/cache_dm_wb_if.sv
// Bus bundle for cache_dm_wb: CPU word port plus block-wide memory port.
// The slave modport is the cache's view. The master modport is the CPU/memory side.
interface cache_dm_wb_if #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADR_WIDTH    = 16,
    parameter int OFFSET_WIDTH = 2
);
    logic [ADR_WIDTH-1:0]                  cpu_address;
    logic [DATA_WIDTH-1:0]                 cpu_wdata;
    logic [DATA_WIDTH-1:0]                 cpu_rdata;
    logic                                  cpu_rd;
    logic                                  cpu_wr;
    logic                                  cpu_ready;
    logic [ADR_WIDTH-OFFSET_WIDTH-1:0]     mem_address;
    logic [(DATA_WIDTH<<OFFSET_WIDTH)-1:0] mem_rdata;
    logic [(DATA_WIDTH<<OFFSET_WIDTH)-1:0] mem_wdata;
    logic                                  mem_rd;
    logic                                  mem_wr;
    logic                                  mem_ready;

    modport slave (
        input  cpu_address, cpu_wdata, cpu_rd, cpu_wr, mem_rdata, mem_ready,
        output cpu_rdata, cpu_ready, mem_address, mem_wdata, mem_rd, mem_wr
    );

    modport master (
        output cpu_address, cpu_wdata, cpu_rd, cpu_wr, mem_rdata, mem_ready,
        input  cpu_rdata, cpu_ready, mem_address, mem_wdata, mem_rd, mem_wr
    );
endinterface

// File: rtl/cache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache between the SAYAC CPU and block memory.
// Defining CACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module cache_dm_wb #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADR_WIDTH    = 16,
    parameter int OFFSET_WIDTH = 2,
    parameter int INDEX_WIDTH  = 6,
    parameter int TAG_WIDTH    = ADR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    cache_dm_wb_if.slave     bus
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]      hit_count,
    output logic [15:0]      miss_count
`endif
);
    localparam int BLOCK_WIDTH = DATA_WIDTH << OFFSET_WIDTH;
    localparam int LINES       = 1 << INDEX_WIDTH;
    localparam int WORDS       = 1 << OFFSET_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WBACK, S_FILL, S_RESP} state_t;

    state_t state, state_n;

    logic [ADR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]  req_wdata;
    logic                   req_wr;
    logic                   first_lookup;

    logic [TAG_WIDTH-1:0]   tag_mem  [LINES];
    logic [BLOCK_WIDTH-1:0] data_mem [LINES];
    logic [LINES-1:0]       valid;
    logic [LINES-1:0]       dirty;

    logic [OFFSET_WIDTH-1:0] req_offset;
    logic [INDEX_WIDTH-1:0]  req_index;
    logic [TAG_WIDTH-1:0]    req_tag;
    logic [BLOCK_WIDTH-1:0]  cur_line;
    logic [BLOCK_WIDTH-1:0]  merged_line;
    logic [DATA_WIDTH-1:0]   cur_word;
    logic                    hit;
    logic                    victim_dirty;
    logic                    fill_done;
    logic                    hit_write;

    assign req_offset   = req_addr[OFFSET_WIDTH-1:0];
    assign req_index    = req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign req_tag      = req_addr[ADR_WIDTH-1 -: TAG_WIDTH];
    assign cur_line     = data_mem[req_index];
    assign hit          = valid[req_index] && (tag_mem[req_index] == req_tag);
    assign victim_dirty = valid[req_index] && dirty[req_index];
    assign fill_done    = (state == S_FILL) && bus.mem_ready;
    assign hit_write    = (state == S_LOOKUP) && hit && req_wr;

    always_comb begin
        cur_word    = '0;
        merged_line = cur_line;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (req_offset == OFFSET_WIDTH'(w)) begin
                cur_word = cur_line[w*DATA_WIDTH +: DATA_WIDTH];
                merged_line[w*DATA_WIDTH +: DATA_WIDTH] = req_wdata;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (bus.cpu_rd || bus.cpu_wr) state_n = S_LOOKUP;
            S_LOOKUP: begin
                if (hit)               state_n = S_RESP;
                else if (victim_dirty) state_n = S_WBACK;
                else                   state_n = S_FILL;
            end
            S_WBACK:  if (bus.mem_ready) state_n = S_FILL;
            S_FILL:   if (bus.mem_ready) state_n = S_LOOKUP;
            S_RESP:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Tag/data arrays carry no reset; writes are suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (fill_done) begin
                data_mem[req_index] <= bus.mem_rdata;
                tag_mem[req_index]  <= req_tag;
            end else if (hit_write) begin
                data_mem[req_index] <= merged_line;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            valid           <= '0;
            dirty           <= '0;
            req_addr        <= '0;
            req_wdata       <= '0;
            req_wr          <= 1'b0;
            first_lookup    <= 1'b0;
            bus.cpu_ready   <= 1'b0;
            bus.cpu_rdata   <= '0;
            bus.mem_rd      <= 1'b0;
            bus.mem_wr      <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_wdata   <= '0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (bus.cpu_rd || bus.cpu_wr) begin
                        req_addr     <= bus.cpu_address;
                        req_wdata    <= bus.cpu_wdata;
                        req_wr       <= bus.cpu_wr && !bus.cpu_rd;
                        first_lookup <= 1'b1;
                    end
                end
                S_LOOKUP: begin
                    first_lookup <= 1'b0;
                    if (hit) begin
                        bus.cpu_ready <= 1'b1;
                        if (req_wr) dirty[req_index] <= 1'b1;
                        else        bus.cpu_rdata    <= cur_word;
                    end else if (victim_dirty) begin
                        bus.mem_address <= {tag_mem[req_index], req_index};
                        bus.mem_wdata   <= cur_line;
                        bus.mem_wr      <= 1'b1;
                    end else begin
                        bus.mem_address <= {req_tag, req_index};
                        bus.mem_rd      <= 1'b1;
                    end
                end
                S_WBACK: begin
                    if (bus.mem_ready) begin
                        bus.mem_wr       <= 1'b0;
                        dirty[req_index] <= 1'b0;
                        bus.mem_address  <= {req_tag, req_index};
                        bus.mem_rd       <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (bus.mem_ready) begin
                        bus.mem_rd       <= 1'b0;
                        valid[req_index] <= 1'b1;
                        dirty[req_index] <= 1'b0;
                    end
                end
                S_RESP:  bus.cpu_ready <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    // Only the first lookup of a captured request is classified; the post-fill retry is not.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == S_LOOKUP && first_lookup) begin
            if (hit) begin
                if (hit_count != '1) hit_count <= hit_count + 16'd1;
            end else begin
                if (miss_count != '1) miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif
endmodule

// File: doc/cache_dm_wb.md
Name: cache_dm_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Sits directly downstream of the SAYAC CPU word interface (rd/wr/address/data/ready) and upstream of a block-wide main-memory model.
- Serves CPU word reads and writes from an internal line array.
- On a miss, writes back a dirty victim block, then fills the line from memory.

Parameters:
- DATA_WIDTH, 16, CPU word width.
- ADR_WIDTH, 16, CPU word address width.
- OFFSET_WIDTH, 2, log2(words per block). Block = 4 x 16 = 64 bits.
- INDEX_WIDTH, 6, log2(number of lines). 64 lines.
- TAG_WIDTH, ADR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH, tag width (derived, 8).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_address  in  ADR_WIDTH  CPU word address.
- cpu_wdata  in  DATA_WIDTH  write data from CPU.
- cpu_rdata  out  DATA_WIDTH  read data to CPU.
- cpu_rd  in  1  read request (level).
- cpu_wr  in  1  write request (level).
- cpu_ready  out  1  one-cycle completion pulse.
- mem_address  out  ADR_WIDTH-OFFSET_WIDTH  block address.
- mem_rdata  in  DATA_WIDTH<<OFFSET_WIDTH  fill block.
- mem_wdata  out  DATA_WIDTH<<OFFSET_WIDTH  write-back block.
- mem_rd  out  1  block read request.
- mem_wr  out  1  block write request.
- mem_ready  in  1  memory completion pulse.

Behaviour:
- Single clock clk. rst is synchronous and active-high.
- Address split: offset = address[1:0], index = [7:2], tag = [15:8]. Word i of a block occupies bits [16i+15:16i].
- Reset, on the rising edge with rst=1:
  - State goes to IDLE.
  - All valid and dirty bits are cleared. Tag and data arrays are not reset.
  - cpu_ready=0, cpu_rdata=0, mem_rd=0, mem_wr=0, mem_address=0, mem_wdata=0.
  - rst mid-operation aborts any transaction: memory requests drop on that edge, no ready pulse is issued, and no array update occurs.
- All outputs are registered.
- IDLE: on an edge where cpu_rd|cpu_wr=1, capture address, wdata and op, then go to LOOKUP. Otherwise stay. cpu_address and cpu_wdata are ignored (X/Z allowed) when no request is present.
- rd and wr both high: treated as a read.
- LOOKUP: hit = valid[index] && tag match.
  - Read hit: cpu_rdata <= selected word, cpu_ready <= 1, go to RESP.
  - Write hit: write the word, dirty <= 1, cpu_ready <= 1, go to RESP.
  - Miss with clean or invalid victim: mem_address <= {tag,index}, mem_rd <= 1, go to FILL.
  - Miss with valid and dirty victim: mem_address <= {victim_tag,index}, mem_wdata <= victim line, mem_wr <= 1, go to WBACK.
- WBACK: hold mem_wr, address and data until mem_ready is sampled 1. Then: mem_wr <= 0, dirty <= 0, mem_address <= {tag,index}, mem_rd <= 1, go to FILL.
- FILL: hold mem_rd until mem_ready is sampled 1. Then: mem_rd <= 0, write mem_rdata to the line, tag updated, valid <= 1, dirty <= 0, go to LOOKUP (the retry is guaranteed to hit).
- RESP: cpu_ready is high for exactly this one cycle. cpu_ready <= 0, go to IDLE. cpu_rdata holds its value until the next read completes.
- Latency:
  - Hit: cpu_ready rises 1 edge after capture.
  - Clean miss: 2 + memory latency.
  - Dirty miss: 2 + two memory latencies.
- mem_rd and mem_wr are never high together, and are never high outside WBACK/FILL.
- mem_ready arriving outside WBACK/FILL is ignored.
- The CPU must drop or change its request in the cycle after cpu_ready. A request still present in IDLE is treated as a new request.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - Adds output ports hit_count[15:0] and miss_count[15:0], each reset to 0.
  - Each increments once per captured request, on that request's first LOOKUP. Retry lookups after a fill are not counted.
  - Both counters saturate at 16'hFFFF.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
1. Cold write miss. After reset, write 0x0010=0x0751.
   -> mem_rd with mem_address=0x0004, no mem_wr.
   -> After mem_ready, a single cpu_ready pulse. Line 4 ends valid and dirty.
2. Write hit, then read hits. Write 0x0011=0x1111 and 0x0012=0x2222.
   -> Each completes with cpu_ready 1 edge after capture and no memory traffic.
   -> Reads of 0x0010, 0x0011, 0x0012 return 0x0751, 0x1111, 0x2222 as hits.
3. Dirty conflict eviction. Read 0x0110 (index 4, tag 0x01).
   -> mem_wr with mem_address=0x0004 and mem_wdata[63:0]={x,0x2222,0x1111,0x0751}.
   -> Then mem_rd with mem_address=0x0044; cpu_rdata = fill word 0.
4. Clean eviction. Read 0x0010 again.
   -> Line is clean, so no mem_wr; only mem_rd at 0x0004.
   -> Data returns 0x0751 (the value from memory after write-back).
5. Reset mid-FILL. Assert rst while mem_rd is high.
   -> mem_rd=0 and cpu_ready=0 on that edge.
   -> A subsequent read of the same address misses (valid cleared).
6. With CACHE_STATS_EN defined, run scenarios 1-4.
   -> hit_count=5, miss_count=3. Retry lookups are not counted.
